// File: rtl/prf_wb_bank_arbiter.sv
// prf_wb_bank_arbiter: per-requestor writeback buffers with
// per-bank round-robin arbitration onto registered WB buses.
module prf_wb_bank_arbiter #(
    parameter int WR_COUNT        = 4,
    parameter int BANK_COUNT      = 4,
    parameter int LOG_PR_COUNT    = 7,
    parameter int LOG_ROB_ENTRIES = 7,
    parameter int DATA_WIDTH      = 32,
    parameter int LOG_BANK_COUNT  = $clog2(BANK_COUNT)
) (
    input  logic CLK,
    input  logic nRST,

    input  logic [WR_COUNT-1:0]                      WB_valid_by_wr,
    input  logic [WR_COUNT-1:0][DATA_WIDTH-1:0]      WB_data_by_wr,
    input  logic [WR_COUNT-1:0][LOG_PR_COUNT-1:0]    WB_PR_by_wr,
    input  logic [WR_COUNT-1:0][LOG_ROB_ENTRIES-1:0] WB_ROB_index_by_wr,
    output logic [WR_COUNT-1:0]                      WB_ready_by_wr,

    input  logic [BANK_COUNT-1:0] bank_stall_by_bank,

    output logic [BANK_COUNT-1:0] WB_bus_valid_by_bank,
    output logic [BANK_COUNT-1:0][DATA_WIDTH-1:0] WB_bus_data_by_bank,
    output logic [BANK_COUNT-1:0][LOG_PR_COUNT-LOG_BANK_COUNT-1:0]
        WB_bus_upper_PR_by_bank,
    output logic [BANK_COUNT-1:0][LOG_ROB_ENTRIES-1:0]
        WB_bus_ROB_index_by_bank
);

    localparam int LOG_WR = (WR_COUNT > 1) ? $clog2(WR_COUNT) : 1;

    logic [WR_COUNT-1:0]                      buf_valid;
    logic [WR_COUNT-1:0][DATA_WIDTH-1:0]      buf_data;
    logic [WR_COUNT-1:0][LOG_PR_COUNT-1:0]    buf_PR;
    logic [WR_COUNT-1:0][LOG_ROB_ENTRIES-1:0] buf_ROB;

    logic [BANK_COUNT-1:0][LOG_WR-1:0] rr_ptr;

    logic [WR_COUNT-1:0]               grant;
    logic [BANK_COUNT-1:0]             bank_grant;
    logic [BANK_COUNT-1:0][LOG_WR-1:0] grant_idx;
    logic [WR_COUNT-1:0]               accept;

    // Per bank: pick the first buffered candidate at or after the RR pointer.
    always_comb begin
        int k;
        logic [LOG_WR-1:0] ki;
        grant      = '0;
        bank_grant = '0;
        grant_idx  = '0;
        k          = 0;
        ki         = '0;
        for (int b = 0; b < BANK_COUNT; b++) begin
            for (int o = 0; o < WR_COUNT; o++) begin
                k = int'(rr_ptr[b]) + o;
                if (k >= WR_COUNT)
                    k = k - WR_COUNT;
                ki = LOG_WR'(k);
                if (!bank_stall_by_bank[b] && !bank_grant[b] &&
                    buf_valid[ki] &&
                    (buf_PR[ki][LOG_BANK_COUNT-1:0] ==
                     LOG_BANK_COUNT'(b))) begin
                    bank_grant[b] = 1'b1;
                    grant_idx[b]  = ki;
                    grant[ki]     = 1'b1;
                end
            end
        end
    end

    // A slot is free if empty or draining this cycle; never looks at valid.
    assign WB_ready_by_wr = ~buf_valid | grant;
    assign accept         = WB_valid_by_wr & WB_ready_by_wr;

    // Buffer entries: load on accept, otherwise clear when granted.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            buf_valid <= '0;
            buf_data  <= '0;
            buf_PR    <= '0;
            buf_ROB   <= '0;
        end else begin
            for (int i = 0; i < WR_COUNT; i++) begin
                if (accept[i]) begin
                    buf_valid[i] <= 1'b1;
                    buf_data[i]  <= WB_data_by_wr[i];
                    buf_PR[i]    <= WB_PR_by_wr[i];
                    buf_ROB[i]   <= WB_ROB_index_by_wr[i];
                end else if (grant[i]) begin
                    buf_valid[i] <= 1'b0;
                end
            end
        end
    end

    // RR pointer moves just past the winner; held when no grant.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr_ptr <= '0;
        end else begin
            for (int b = 0; b < BANK_COUNT; b++) begin
                if (bank_grant[b]) begin
                    if (grant_idx[b] == LOG_WR'(WR_COUNT - 1))
                        rr_ptr[b] <= '0;
                    else
                        rr_ptr[b] <= grant_idx[b] + 1'b1;
                end
            end
        end
    end

    // Registered WB bus per bank; payload holds when idle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            WB_bus_valid_by_bank     <= '0;
            WB_bus_data_by_bank      <= '0;
            WB_bus_upper_PR_by_bank  <= '0;
            WB_bus_ROB_index_by_bank <= '0;
        end else begin
            for (int b = 0; b < BANK_COUNT; b++) begin
                WB_bus_valid_by_bank[b] <= bank_grant[b];
                if (bank_grant[b]) begin
                    WB_bus_data_by_bank[b] <= buf_data[grant_idx[b]];
                    WB_bus_upper_PR_by_bank[b] <=
                        buf_PR[grant_idx[b]][LOG_PR_COUNT-1:LOG_BANK_COUNT];
                    WB_bus_ROB_index_by_bank[b] <= buf_ROB[grant_idx[b]];
                end
            end
        end
    end

endmodule
